// File: rtl/uart_pkg.sv
// Shared definitions for the sample transmitter.
//   - parity-mode constants (PAR_NONE / PAR_EVEN / PAR_ODD)
//   - transmitter state type
//   - ceil_div, used to size the number of frames per sample
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } tx_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator for the sample transmitter.
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   clear       in   restart the bit time (asserted on accept)
//   bit_end     out  high in the last cycle of a bit time (count = CLK_DIV-1)
//   bit_pre_end out  high one cycle before bit_end (count = CLK_DIV-2)
module uart_baud_gen #(
    parameter int CLK_DIV = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_DIV - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_end     = (count == CNT_LAST);
    assign bit_pre_end = (count == CNT_PRE);

endmodule

// File: rtl/uart_sample_tx.sv
// Serialises a DATA_W-bit sample into NUM_FRAMES tagged 8-bit RS232 frames.
// Each frame: start, 7 payload bits + tag bit (1 only on the last frame),
// optional parity, STOP_BITS stop bits, GAP_BITS idle bits.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   din       in   sample to send
//   in_valid  in   sample offered (ignored when FREE_RUN=1)
//   in_ready  out  block can accept a sample
//   tx        out  serial line, idle high
//   busy      out  sample in flight
//   done      out  one-cycle pulse when in_ready returns after a sample
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line idle, in_ready high, waiting for a sample
// ST_START  | start bit (tx=0)
// ST_DATA   | 8 data bits, LSB first, bit_idx = bit number
// ST_PARITY | parity over the 8 data bits
// ST_STOP   | stop bits, bit_idx counts them
// ST_GAP    | idle-high gap bits, bit_idx counts them
module uart_sample_tx
    import uart_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 5208,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1,
    parameter int GAP_BITS  = 1,
    parameter int FREE_RUN  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int NUM_FRAMES = ceil_div(DATA_W, 7);
    localparam int SHADOW_W   = NUM_FRAMES * 7;
    localparam int FW         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [3:0]    GAP_LAST   = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic          PAR_INV    = (PARITY == PAR_ODD);
    localparam logic          ALWAYS_VALID = (FREE_RUN != 0);

    tx_state_t         state;
    logic [FW-1:0]     frame_idx;
    logic [3:0]        bit_idx;
    logic [SHADOW_W-1:0] shadow;
    logic              par_acc;

    logic              accept;
    logic              bit_end;
    logic              bit_pre_end;
    logic [7:0]        frame_byte;
    logic [2:0]        nxt_idx;
    logic              last_bit;
    logic              final_bit;
    logic              frame_wrap;

    assign accept = (state == ST_IDLE) && in_ready && (in_valid || ALWAYS_VALID);

    uart_baud_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    // The shadow shifts down 7 bits per frame, so the current payload is always [6:0].
    assign frame_byte = {(frame_idx == FRAME_LAST), shadow[6:0]};
    assign nxt_idx    = bit_idx[2:0] + 3'd1;

    // last_bit: in the final bit of a frame (last gap bit, or last stop bit if no gap).
    always_comb begin
        last_bit = 1'b0;
        if (GAP_BITS > 0) begin
            last_bit = (state == ST_GAP) && (bit_idx == GAP_LAST);
        end else begin
            last_bit = (state == ST_STOP) && (bit_idx == STOP_LAST);
        end
    end

    // The sample ends one cycle early so in_ready/done land in the last cycle of the
    // final idle-high bit; a back-to-back accept then starts with no extra idle.
    assign final_bit  = last_bit && (frame_idx == FRAME_LAST) && bit_pre_end;
    assign frame_wrap = last_bit && (frame_idx != FRAME_LAST) && bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_idx <= '0;
            bit_idx   <= '0;
            par_acc   <= 1'b0;
            shadow    <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                tx       <= 1'b1;
                busy     <= 1'b0;
                in_ready <= 1'b1;
                if (accept) begin
                    shadow    <= SHADOW_W'(din);
                    state     <= ST_START;
                    tx        <= 1'b0;
                    in_ready  <= 1'b0;
                    busy      <= 1'b1;
                    frame_idx <= '0;
                    bit_idx   <= '0;
                    par_acc   <= 1'b0;
                end
            end else if (final_bit) begin
                state    <= ST_IDLE;
                tx       <= 1'b1;
                in_ready <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b1;
            end else if (frame_wrap) begin
                state     <= ST_START;
                tx        <= 1'b0;
                frame_idx <= frame_idx + FW'(1);
                shadow    <= shadow >> 7;
                bit_idx   <= '0;
                par_acc   <= 1'b0;
            end else if (bit_end) begin
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        tx      <= frame_byte[0];
                        par_acc <= frame_byte[0];
                    end
                    ST_DATA: begin
                        if (bit_idx != 4'd7) begin
                            bit_idx <= bit_idx + 4'd1;
                            tx      <= frame_byte[nxt_idx];
                            par_acc <= par_acc ^ frame_byte[nxt_idx];
                        end else if (PARITY != PAR_NONE) begin
                            state <= ST_PARITY;
                            tx    <= par_acc ^ PAR_INV;
                        end else begin
                            state   <= ST_STOP;
                            bit_idx <= '0;
                            tx      <= 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        state   <= ST_STOP;
                        bit_idx <= '0;
                        tx      <= 1'b1;
                    end
                    ST_STOP: begin
                        tx <= 1'b1;
                        if (bit_idx != STOP_LAST) begin
                            bit_idx <= bit_idx + 4'd1;
                        end else begin
                            state   <= ST_GAP;
                            bit_idx <= '0;
                        end
                    end
                    ST_GAP: begin
                        tx      <= 1'b1;
                        bit_idx <= bit_idx + 4'd1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_sample_tx.sv
// Bench for uart_sample_tx: four instances with different configurations,
// a bit-stream model checked every cycle, and literal frame/latency checks.
module tb_uart_sample_tx;

    localparam int DIV = 4;
    localparam int C_DW[4]   = '{12, 12, 12, 14};
    localparam int C_PAR[4]  = '{1, 2, 1, 0};
    localparam int C_STOP[4] = '{1, 2, 1, 1};
    localparam int C_GAP[4]  = '{1, 1, 1, 0};
    localparam int C_FR[4]   = '{0, 0, 1, 0};

    logic        clk;
    logic        rst_a [4];
    logic        val_a [4];
    logic [15:0] din_a [4];
    logic [11:0] din_fr;
    logic        tx_a  [4];
    logic        rdy_a [4];
    logic        busy_a[4];
    logic        done_a[4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model state
    logic        m_rdy [4];
    logic        m_done[4];
    int          m_ph  [4];
    logic [15:0] m_smp [4];
    logic        txlog [4][256];
    int          fr_acc[8];
    int          fr_n = 0;

    uart_sample_tx #(.DATA_W(12), .CLK_DIV(DIV), .PARITY(1), .STOP_BITS(1), .GAP_BITS(1), .FREE_RUN(0)) dut0 (
        .clk(clk), .rst(rst_a[0]), .din(din_a[0][11:0]), .in_valid(val_a[0]),
        .in_ready(rdy_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .done(done_a[0]));
    uart_sample_tx #(.DATA_W(12), .CLK_DIV(DIV), .PARITY(2), .STOP_BITS(2), .GAP_BITS(1), .FREE_RUN(0)) dut1 (
        .clk(clk), .rst(rst_a[1]), .din(din_a[1][11:0]), .in_valid(val_a[1]),
        .in_ready(rdy_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .done(done_a[1]));
    uart_sample_tx #(.DATA_W(12), .CLK_DIV(DIV), .PARITY(1), .STOP_BITS(1), .GAP_BITS(1), .FREE_RUN(1)) dut2 (
        .clk(clk), .rst(rst_a[2]), .din(din_fr), .in_valid(val_a[2]),
        .in_ready(rdy_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .done(done_a[2]));
    uart_sample_tx #(.DATA_W(14), .CLK_DIV(DIV), .PARITY(0), .STOP_BITS(1), .GAP_BITS(0), .FREE_RUN(0)) dut3 (
        .clk(clk), .rst(rst_a[3]), .din(din_a[3][13:0]), .in_valid(val_a[3]),
        .in_ready(rdy_a[3]), .tx(tx_a[3]), .busy(busy_a[3]), .done(done_a[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h at cycle %0d", nm, id, act, exp, cyc);
        end
    endtask

    function automatic int n_frames(input int id);
        return (C_DW[id] + 6) / 7;
    endfunction

    function automatic int frame_bits(input int id);
        return 10 + ((C_PAR[id] != 0) ? 1 : 0) + C_STOP[id] - 1 + C_GAP[id];
    endfunction

    function automatic int sample_len(input int id);
        return n_frames(id) * frame_bits(id) * DIV;
    endfunction

    // Expected line level ph cycles after accept, from frame layout arithmetic.
    function automatic logic model_tx(input int id, input logic [15:0] smp, input int ph);
        int b, k, pos;
        logic [7:0] byt;
        b   = (ph - 1) / DIV;
        k   = b / frame_bits(id);
        pos = b % frame_bits(id);
        byt = 8'((smp >> (7 * k)) & 16'h007F);
        byt[7] = (k == n_frames(id) - 1);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return byt[pos-1];
        if (pos == 9 && C_PAR[id] != 0) return (^byt) ^ (C_PAR[id] == 2);
        return 1'b1;
    endfunction

    function automatic logic [7:0] got_byte(input int id, input int k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++)
            r[i] = txlog[id][2 + (k * frame_bits(id) + 1 + i) * DIV];
        return r;
    endfunction

    function automatic logic got_par(input int id, input int k);
        return txlog[id][2 + (k * frame_bits(id) + 9) * DIV];
    endfunction

    // Compare process: every cycle, every instance.
    initial begin
        for (int id = 0; id < 4; id++) begin
            m_rdy[id] = 1'b0; m_done[id] = 1'b0; m_ph[id] = 0; m_smp[id] = '0;
        end
        forever begin
            @(negedge clk);
            for (int id = 0; id < 4; id++) begin
                logic ex_tx;
                ex_tx = (m_ph[id] > 0) ? model_tx(id, m_smp[id], m_ph[id]) : 1'b1;
                chk("tx", id, 32'(tx_a[id]), 32'(ex_tx));
                chk("in_ready", id, 32'(rdy_a[id]), 32'(m_rdy[id]));
                chk("busy", id, 32'(busy_a[id]), 32'(m_ph[id] > 0));
                chk("done", id, 32'(done_a[id]), 32'(m_done[id]));
                if (m_ph[id] > 0 && m_ph[id] < 256) txlog[id][m_ph[id]] = tx_a[id];
                if (rst_a[id]) begin
                    m_rdy[id] = 1'b0; m_ph[id] = 0; m_done[id] = 1'b0;
                end else if (m_ph[id] > 0) begin
                    if (m_ph[id] == sample_len(id) - 1) begin
                        m_ph[id] = 0; m_rdy[id] = 1'b1; m_done[id] = 1'b1;
                    end else begin
                        m_ph[id]++;
                    end
                end else begin
                    m_done[id] = 1'b0;
                    if (m_rdy[id] && (val_a[id] || C_FR[id] != 0)) begin
                        m_smp[id] = (id == 2) ? {4'h0, din_fr} : din_a[id];
                        m_ph[id]  = 1;
                        m_rdy[id] = 1'b0;
                        if (id == 2 && fr_n < 8) begin
                            fr_acc[fr_n] = cyc;
                            fr_n++;
                        end
                    end else begin
                        m_rdy[id] = 1'b1;
                    end
                end
            end
        end
    end

    // Free-run sample source steps every cycle.
    initial begin
        din_fr = 12'h0AB;
        forever begin
            @(posedge clk);
            #1 din_fr = din_fr + 12'h1F3;
        end
    end

    // Offer v to instance id; returns the accept cycle.
    task automatic send(input int id, input logic [15:0] v, output int acc);
        int n;
        @(posedge clk);
        #1;
        din_a[id] = v;
        val_a[id] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy_a[id] && n < 300);
        chk("send_ready", id, 32'(rdy_a[id]), 32'd1);
        acc = cyc;
        @(posedge clk);
        #1 val_a[id] = 1'b0;
    endtask

    task automatic wait_done(input int id, output int when);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_a[id] && n < 300);
        chk("done_seen", id, 32'(done_a[id]), 32'd1);
        when = cyc;
    endtask

    initial begin
        int a, d, cnt;
        for (int id = 0; id < 4; id++) begin
            rst_a[id] = 1'b1; val_a[id] = 1'b0; din_a[id] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", 0, 32'(tx_a[0]), 32'd1);
        chk("rst_ready", 0, 32'(rdy_a[0]), 32'd0);
        chk("rst_busy", 0, 32'(busy_a[0]), 32'd0);
        @(posedge clk);
        #1;
        for (int id = 0; id < 4; id++) rst_a[id] = 1'b0;
        @(negedge clk);
        chk("ready_pre", 0, 32'(rdy_a[0]), 32'd0);
        @(negedge clk);
        chk("ready_post_rst", 0, 32'(rdy_a[0]), 32'd1);

        // even parity, 1 stop, 1 gap
        send(0, 16'h0A5C, a);
        wait_done(0, d);
        chk("t1_latency", 0, 32'(d - a), 32'd96);
        chk("t1_f0_byte", 0, 32'(got_byte(0, 0)), 32'h5C);
        chk("t1_f0_par", 0, 32'(got_par(0, 0)), 32'd0);
        chk("t1_f1_byte", 0, 32'(got_byte(0, 1)), 32'h94);
        chk("t1_f1_par", 0, 32'(got_par(0, 1)), 32'd1);

        // in_valid pulsed while busy
        send(0, 16'h03C3, a);
        repeat (30) @(posedge clk);
        #1;
        din_a[0] = 16'h0111;
        val_a[0] = 1'b1;
        @(posedge clk);
        #1 val_a[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done_a[0]) cnt++;
        end
        chk("t6_done_count", 0, 32'(cnt), 32'd1);

        // reset mid-frame, in cycle 20 of frame 0 (data bit 4 = 0)
        send(0, 16'h05A5, a);
        repeat (19) @(posedge clk);
        #1 rst_a[0] = 1'b1;
        @(posedge clk);
        #1 rst_a[0] = 1'b0;
        @(negedge clk);
        chk("t4_tx", 0, 32'(tx_a[0]), 32'd1);
        chk("t4_ready", 0, 32'(rdy_a[0]), 32'd0);
        chk("t4_busy", 0, 32'(busy_a[0]), 32'd0);
        @(negedge clk);
        chk("t4_ready_back", 0, 32'(rdy_a[0]), 32'd1);
        send(0, 16'h0123, a);
        wait_done(0, d);
        chk("t4_latency", 0, 32'(d - a), 32'd96);
        chk("t4_f0_byte", 0, 32'(got_byte(0, 0)), 32'h23);
        chk("t4_f0_par", 0, 32'(got_par(0, 0)), 32'd1);
        chk("t4_f1_byte", 0, 32'(got_byte(0, 1)), 32'h82);

        // odd parity, 2 stop bits
        send(1, 16'h0000, a);
        wait_done(1, d);
        chk("t2_latency", 1, 32'(d - a), 32'd104);
        chk("t2_f0_byte", 1, 32'(got_byte(1, 0)), 32'h00);
        chk("t2_f0_par", 1, 32'(got_par(1, 0)), 32'd1);
        chk("t2_f1_byte", 1, 32'(got_byte(1, 1)), 32'h80);
        chk("t2_f1_par", 1, 32'(got_par(1, 1)), 32'd0);

        // 14-bit sample, no parity, no gap
        send(3, 16'h3FFF, a);
        wait_done(3, d);
        chk("t5_latency", 3, 32'(d - a), 32'd80);
        chk("t5_f0_byte", 3, 32'(got_byte(3, 0)), 32'h7F);
        chk("t5_f1_byte", 3, 32'(got_byte(3, 1)), 32'hFF);

        // free-run: back-to-back accepts exactly one sample length apart
        chk("t3_accepts", 2, 32'(fr_n >= 5), 32'd1);
        chk("t3_gap01", 2, 32'(fr_acc[1] - fr_acc[0]), 32'd96);
        chk("t3_gap12", 2, 32'(fr_acc[2] - fr_acc[1]), 32'd96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
